debug_display: RTL and testbench

DEBUG_DISPLAY -- requirements
Module: debug_display

---
 rtl/debug_display_pkg.sv | 37 +++
 rtl/debug_display_hex7seg.sv | 14 +
 rtl/debug_display.sv | 134 +++++++++++++
 tb/tb_debug_display.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/debug_display_pkg.sv
// Shared definitions for the seven-segment debug display.
// Latency: none (constants, types and a table only).
// Backpressure: not applicable.
`timescale 1ns/100ps
package debug_display_pkg;

    // Segment bit positions inside the 8-bit active-low segment bus {dp,g,f,e,d,c,b,a}
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // All segments off (active low)
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // All digit enables off (active low)
    localparam logic [3:0] AN_BLANK = 4'b1111;

    // Active-low {g,f,e,d,c,b,a} patterns, entry [h] is hex digit h
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
        7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // Which 16-bit half of the snapshot is being shown
    typedef enum logic {
        HALF_LOW  = 1'b0,
        HALF_HIGH = 1'b1
    } half_e;

endpackage

// File: rtl/debug_display_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder (dp not included).
// Latency: zero cycles, purely combinational.
// Backpressure: none, output follows input continuously.
`timescale 1ns/100ps
module hex7seg
    import debug_display_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_hex];

endmodule

// File: rtl/debug_display.sv
// Multiplexed 4-digit hex display of the PC or a probed memory word, 16 bits at a time.
// Latency: switches reach mem_raddr after 2 cycles; an/seg are registered one cycle after the digit state.
// Backpressure: none; the display free-runs and only samples its sources at frame start.
`timescale 1ns/100ps
module debug_display
    import debug_display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int HALF_FRAMES  = 250
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        sw_sel,
    input  logic [6:0]  sw_addr,
    input  logic [31:0] pc,
    output logic [6:0]  mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int DW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int FW = (HALF_FRAMES  > 1) ? $clog2(HALF_FRAMES)  : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DIGIT_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(HALF_FRAMES - 1);

    logic          r_sel_s1;
    logic          r_sel_s2;
    logic [6:0]    r_addr_s1;
    logic [6:0]    r_addr_s2;
    logic [31:0]   r_capture;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_digit;
    logic [FW-1:0] r_frame;
    half_e         r_half;
    logic [31:0]   r_snap;
    logic [3:0]    r_an;
    logic [7:0]    r_seg;

    logic          w_dwell_wrap;
    logic          w_frame_end;
    logic          w_frame_wrap;
    logic          w_frame_start;
    logic [15:0]   w_half_word;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg7;
    logic          w_dp_n;

    assign w_dwell_wrap  = (r_dwell == DWELL_LAST);
    assign w_frame_end   = w_dwell_wrap && (r_digit == 2'd3);
    assign w_frame_wrap  = w_frame_end && (r_frame == FRAME_LAST);
    assign w_frame_start = (r_dwell == '0) && (r_digit == 2'd0);

    // Digit selection works on the frozen snapshot so the visible word never tears
    assign w_half_word = (r_half == HALF_HIGH) ? r_snap[31:16] : r_snap[15:0];
    assign w_nibble    = w_half_word[{r_digit, 2'b00} +: 4];
    // Decimal point marks the leftmost digit while the upper half-word is shown
    assign w_dp_n      = !((r_digit == 2'd3) && (r_half == HALF_HIGH));

    assign mem_raddr = r_addr_s2;
    assign an        = r_an;
    assign seg       = r_seg;

    hex7seg u_hex7seg (
        .i_hex (w_nibble),
        .o_seg (w_seg7)
    );

    // Two-flop synchronizers for the asynchronous switches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_s1  <= 1'b0;
            r_sel_s2  <= 1'b0;
            r_addr_s1 <= '0;
            r_addr_s2 <= '0;
        end else begin
            r_sel_s1  <= sw_sel;
            r_sel_s2  <= r_sel_s1;
            r_addr_s1 <= sw_addr;
            r_addr_s2 <= r_addr_s1;
        end
    end

    // Register the memory word returned one cycle after mem_raddr
    always_ff @(posedge clk) begin
        if (rst) begin
            r_capture <= '0;
        end else begin
            r_capture <= mem_rdata;
        end
    end

    // Dwell, digit, frame and half sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell <= '0;
            r_digit <= 2'd0;
            r_frame <= '0;
            r_half  <= HALF_LOW;
        end else begin
            r_dwell <= w_dwell_wrap ? '0 : r_dwell + 1'b1;
            if (w_dwell_wrap) begin
                r_digit <= r_digit + 2'd1;
            end
            if (w_frame_end) begin
                r_frame <= w_frame_wrap ? '0 : r_frame + 1'b1;
            end
            if (w_frame_wrap) begin
                r_half <= (r_half == HALF_LOW) ? HALF_HIGH : HALF_LOW;
            end
        end
    end

    // Freeze the source word once per frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap <= '0;
        end else if (w_frame_start) begin
            r_snap <= r_sel_s2 ? r_capture : pc;
        end
    end

    // Registered digit enable and segment outputs, changing together
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= AN_BLANK;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(4'b0001 << r_digit);
            r_seg <= {w_dp_n, w_seg7};
        end
    end

endmodule

// File: tb/tb_debug_display.sv
// Directed bench for debug_display with a cycle-level reference model and literal spot checks.
// Latency: model predicts outputs after every rising edge and compares at the falling edge.
// Backpressure: not applicable; stimulus is time-driven.
`timescale 1ns/100ps
module tb_debug_display;

    localparam int DC    = 2;
    localparam int HF    = 2;
    localparam int FRAME = 4 * DC;
    localparam int HMAX  = 4096;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        sw_sel    = 1'b0;
    logic [6:0]  sw_addr   = 7'd0;
    logic [31:0] pc        = 32'h1234ABCD;
    logic [6:0]  mem_raddr;
    logic [31:0] mem_rdata = 32'd0;
    logic [3:0]  an;
    logic [7:0]  seg;

    logic [31:0] mem [128];

    int n_cmp  = 0;
    int n_bad  = 0;
    int p_now  = -1;

    always #1 clk = ~clk;

    debug_display #(
        .DIGIT_CYCLES (DC),
        .HALF_FRAMES  (HF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_sel    (sw_sel),
        .sw_addr   (sw_addr),
        .pc        (pc),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .an        (an),
        .seg       (seg)
    );

    // Synchronous-read data memory
    always @(posedge clk) mem_rdata <= mem[mem_raddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Active-low segment patterns straight from the hex table, dp off
    function automatic logic [7:0] seg_of(input logic [3:0] h);
        case (h)
            4'h0: seg_of = 8'hC0;  4'h1: seg_of = 8'hF9;
            4'h2: seg_of = 8'hA4;  4'h3: seg_of = 8'hB0;
            4'h4: seg_of = 8'h99;  4'h5: seg_of = 8'h92;
            4'h6: seg_of = 8'h82;  4'h7: seg_of = 8'hF8;
            4'h8: seg_of = 8'h80;  4'h9: seg_of = 8'h90;
            4'hA: seg_of = 8'h88;  4'hB: seg_of = 8'h83;
            4'hC: seg_of = 8'hC6;  4'hD: seg_of = 8'hA1;
            4'hE: seg_of = 8'h86;  default: seg_of = 8'h8E;
        endcase
    endfunction

    // Reference model: position p counts edges since reset release; everything follows from p
    logic        h_sel  [HMAX];
    logic [6:0]  h_addr [HMAX];
    logic [31:0] h_pc   [HMAX];
    logic        h_rst  [HMAX];

    initial begin : model
        int          g;
        int          nrel;
        int          p;
        int          digit;
        logic        e_half;
        logic        e_live;
        logic        sel_sync;
        logic [31:0] snap_m;
        logic [15:0] hw;
        logic [3:0]  nib;
        logic [3:0]  e_an;
        logic [7:0]  e_seg;
        logic [6:0]  e_raddr;
        g      = 0;
        nrel   = 0;
        snap_m = 32'd0;
        e_half = 1'b0;
        forever begin
            @(posedge clk);
            if (g >= HMAX) begin
                $display("FAIL history_overflow: got %0d edges, expected below %0d", g, HMAX);
                n_bad++;
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $fatal(1, "history exhausted");
            end
            h_sel[g]  = sw_sel;
            h_addr[g] = sw_addr;
            h_pc[g]   = pc;
            h_rst[g]  = rst;
            if (rst) begin
                e_live  = 1'b0;
                e_an    = 4'b1111;
                e_seg   = 8'hFF;
                e_raddr = 7'd0;
                nrel    = 0;
                snap_m  = 32'd0;
                e_half  = 1'b0;
            end else begin
                p       = nrel;
                digit   = (p / DC) % 4;
                e_half  = (((p / FRAME) / HF) % 2) == 1;
                hw      = e_half ? snap_m[31:16] : snap_m[15:0];
                nib     = 4'(hw >> (4 * digit));
                e_an    = ~(4'b0001 << digit);
                e_seg   = seg_of(nib);
                e_seg[7] = !(digit == 3 && e_half);
                e_raddr = (g >= 1 && !h_rst[g-1]) ? h_addr[g-1] : 7'd0;
                if (p % FRAME == 0) begin
                    sel_sync = (g >= 2) && !h_rst[g-1] && !h_rst[g-2] && h_sel[g-2];
                    snap_m   = (sel_sync && g >= 4) ? mem[h_addr[g-4]] : h_pc[g];
                end
                nrel++;
                e_live = 1'b1;
            end
            g++;
            @(negedge clk);
            chk("model_an", 32'(an), 32'(e_an));
            chk("model_seg", 32'(seg), 32'(e_seg));
            chk("model_raddr", 32'(mem_raddr), 32'(e_raddr));
            if (e_live) begin
                chk("one_hot_an", 32'($countones(~an)), 32'd1);
                chk("dp_rule", {31'd0, seg[7]}, {31'd0, !(an == 4'b0111 && e_half)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        p_now++;
        #0.5;
    endtask

    task automatic tick_to(input int t);
        while (p_now < t) tick();
    endtask

    // Directed stimulus with hand-computed spot values
    initial begin : stim
        for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[5] = 32'h0000_00F1;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #0.5;
            chk("rst_an", 32'(an), 32'hF);
            chk("rst_seg", 32'(seg), 32'hFF);
            chk("rst_raddr", 32'(mem_raddr), 32'h0);
        end
        rst   = 1'b0;
        p_now = -1;

        tick_to(0);  chk("first_an", 32'(an), 32'hE); chk("first_seg_zero", 32'(seg), 32'hC0);
        tick_to(1);  chk("d0_D", 32'(seg), 32'hA1);
        tick_to(2);  chk("d1_an", 32'(an), 32'hD); chk("d1_C", 32'(seg), 32'hC6);
        tick_to(4);  chk("d2_an", 32'(an), 32'hB); chk("d2_B", 32'(seg), 32'h83);
        tick_to(6);  chk("d3_an", 32'(an), 32'h7); chk("d3_A_nodp", 32'(seg), 32'h88);
        tick_to(16); chk("hi_d0_an", 32'(an), 32'hE); chk("hi_d0_4", 32'(seg), 32'h99);
        tick_to(18); chk("hi_d1_3", 32'(seg), 32'hB0);
        tick_to(20); chk("hi_d2_2", 32'(seg), 32'hA4);
        tick_to(22); chk("hi_d3_an", 32'(an), 32'h7); chk("hi_d3_1_dp", 32'(seg), 32'h79);

        tick_to(36); pc = 32'h5678_9E0F;
        tick_to(38); chk("tear_d3_old", 32'(seg), 32'h88);
        tick_to(41); chk("new_d0_F", 32'(seg), 32'h8E);
        tick_to(43); chk("new_d1_0", 32'(seg), 32'hC0);

        tick_to(57); sw_sel = 1'b1; sw_addr = 7'd5;
        tick_to(58); chk("raddr_1cyc", 32'(mem_raddr), 32'h0);
        tick_to(59); chk("raddr_2cyc", 32'(mem_raddr), 32'h5);
        tick_to(65); chk("mem_d0_an", 32'(an), 32'hE); chk("mem_d0_1", 32'(seg), 32'hF9);
        tick_to(66); chk("mem_d1_an", 32'(an), 32'hD); chk("mem_d1_F", 32'(seg), 32'h8E);
        tick_to(70); sw_sel = 1'b0; sw_addr = 7'd0;

        tick_to(84); rst = 1'b1;
        tick();
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg", 32'(seg), 32'hFF);
        chk("midrst_raddr", 32'(mem_raddr), 32'h0);
        rst   = 1'b0;
        p_now = -1;
        tick_to(0);  chk("rerun_an", 32'(an), 32'hE); chk("rerun_seg_zero", 32'(seg), 32'hC0);
        tick_to(1);  chk("rerun_low_F", 32'(seg), 32'h8E);
        tick_to(2);  chk("rerun_d1_an", 32'(an), 32'hD); chk("rerun_d1_0", 32'(seg), 32'hC0);
        tick_to(24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
